// File: rtl/mem_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mem_scan_ctrl                                                     |
// | Brief  : Host-write / max-scan port arbiter for a single-port data memory  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module mem_scan_ctrl #(
  parameter int AW = 6,
  parameter int DW = 8
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          start,
  input  logic          wr,
  input  logic [AW-1:0] AB,
  input  logic [DW-1:0] DB,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] max_val,
  output logic [AW-1:0] max_addr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [AW-1:0] c_LAST_ADDR = '1;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_rd_tag;
  logic          r_rd_vld;
  logic [DW-1:0] r_max_val;
  logic [AW-1:0] r_max_addr;
  logic          w_issue;
  logic          w_accept;
  logic          w_hit;

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = SCAN;
        end
      end
      SCAN: begin
        // a host write owns the port this cycle, so the read is deferred
        if (!wr) begin
          w_issue = 1'b1;
          if (r_rd_ptr == c_LAST_ADDR) begin
            w_state_nxt = DRAIN;
          end
        end
      end
      DRAIN:   w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_we    = wr;
    mem_wdata = DB;
    if (wr) begin
      mem_addr = AB;
    end else if (r_state == SCAN) begin
      mem_addr = r_rd_ptr;
    end else begin
      mem_addr = '0;
    end
  end

  // strict compare keeps the lowest address on ties
  assign w_hit    = r_rd_vld && (mem_rdata > r_max_val);
  assign busy     = (r_state == SCAN) || (r_state == DRAIN);
  assign done     = (r_state == DONE);
  assign max_val  = r_max_val;
  assign max_addr = r_max_addr;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state    <= IDLE;
      r_rd_ptr   <= '0;
      r_rd_tag   <= '0;
      r_rd_vld   <= 1'b0;
      r_max_val  <= '0;
      r_max_addr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rd_vld <= w_issue;
      if (w_issue) begin
        r_rd_tag <= r_rd_ptr;
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_accept) begin
        r_rd_ptr   <= '0;
        r_max_val  <= '0;
        r_max_addr <= '0;
      end else if (w_hit) begin
        r_max_val  <= mem_rdata;
        r_max_addr <= r_rd_tag;
      end
    end
  end

endmodule
`default_nettype wire
